// File: rtl/pmem_responder_pkg.sv
// ============================================================================
// pmem_responder_pkg : shared LC-3b memory-side types and responder states
// Rev 1.0
// ============================================================================
`default_nettype none

package pmem_responder_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_pmem_line;

  localparam int lc3b_pmem_offset_bits = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } pmem_resp_state_t;

endpackage

`default_nettype wire

// File: rtl/pmem_responder_if.sv
// ============================================================================
// pmem_responder_if : 128-bit line request/response bus to physical memory
// Rev 1.0
// ============================================================================
`default_nettype none

interface pmem_responder_if;
  import pmem_responder_pkg::*;

  logic          pmem_read;
  logic          pmem_write;
  lc3b_word      pmem_address;
  lc3b_pmem_line pmem_wdata;
  lc3b_pmem_line pmem_rdata;
  logic          pmem_resp;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

endinterface

`default_nettype wire

// File: rtl/pmem_responder_line_array.sv
// ============================================================================
// pmem_line_array : DEPTH x 128-bit line storage, async clear, 1W/1R(comb)
// Rev 1.0
// ============================================================================
`default_nettype none

module pmem_line_array
  import pmem_responder_pkg::*;
#(
  parameter int INDEX_BITS = 3
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  we_i,
  input  wire logic [INDEX_BITS-1:0] waddr_i,
  input  lc3b_pmem_line              wdata_i,
  input  wire logic [INDEX_BITS-1:0] raddr_i,
  output lc3b_pmem_line              rdata_o
);

  localparam int DEPTH = 2 ** INDEX_BITS;

  lc3b_pmem_line lines_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        lines_q[i] <= '0;
      end
    end else if (we_i) begin
      lines_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = lines_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/pmem_responder.sv
// ============================================================================
// pmem_responder : fixed-latency line read/write responder over a line array
// Rev 1.0
// ============================================================================
`default_nettype none

module pmem_responder
  import pmem_responder_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int INDEX_BITS = 3
) (
  input  wire logic        clk,
  input  wire logic        rst,
  pmem_responder_if.slave  bus
);

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  pmem_resp_state_t        state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    op_we_q, op_we_d;
  logic [INDEX_BITS-1:0]   idx_q, idx_d;
  lc3b_pmem_line           wdata_q, wdata_d;
  lc3b_pmem_line           rdata_q, rdata_d;

  logic [INDEX_BITS-1:0]   w_req_idx;
  logic [INDEX_BITS-1:0]   w_arr_raddr;
  lc3b_pmem_line           w_arr_rdata;
  logic                    w_arr_we;
  logic                    w_unused_addr;

  assign w_req_idx     = bus.pmem_address[lc3b_pmem_offset_bits +: INDEX_BITS];
  assign w_unused_addr = ^{bus.pmem_address[15:lc3b_pmem_offset_bits+INDEX_BITS],
                           bus.pmem_address[lc3b_pmem_offset_bits-1:0]};

  // A LATENCY=1 read goes straight from IDLE to RESP, so the array must be
  // addressed by the live request in IDLE and by the latched index otherwise.
  assign w_arr_raddr = (state_q == IDLE) ? w_req_idx : idx_q;
  assign w_arr_we    = (state_q == RESP) && op_we_q;

  pmem_line_array #(
    .INDEX_BITS (INDEX_BITS)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (w_arr_we),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (w_arr_raddr),
    .rdata_o (w_arr_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_we_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_we_q <= op_we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_we_d = op_we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.pmem_read || bus.pmem_write) begin
          op_we_d = bus.pmem_write;
          idx_d   = w_req_idx;
          wdata_d = bus.pmem_wdata;
          cnt_d   = LAT_M1;
          if (LATENCY > 1) begin
            state_d = BUSY;
          end else begin
            state_d = RESP;
            if (!bus.pmem_write) rdata_d = w_arr_rdata;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          if (!op_we_q) rdata_d = w_arr_rdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.pmem_rdata = rdata_q;
  assign bus.pmem_resp  = (state_q == RESP);

endmodule

`default_nettype wire
